// File: rtl/regfile_seq_pkg.sv
// Shared constants for the register-file sequencer: data/index widths,
// opcode encodings and the sequencer FSM state encoding.
package regfile_seq_pkg;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 2;

    // Opcode encodings; 3'b101..3'b111 are illegal.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_LDI = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/rf_alu.sv
// Combinational operation unit for the register-file sequencer.
// Illegal opcodes yield a zero result with err raised.
module rf_alu
    import regfile_seq_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    // Select the operation result; wrap-around arithmetic, carry dropped.
    always_comb begin
        result = {DATA_W{1'b0}};
        err    = 1'b0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_LDI:  result = imm;
            default: begin
                result = {DATA_W{1'b0}};
                err    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Command-driven initiator for the 4x32 register file. One command at a time:
// read both operands, compute, write back once, then hold the response until
// it is consumed. The write-back port is driven from falling-edge flops so the
// file sees RegWrite/index/data stable across exactly one rising edge.
module regfile_sequencer
    import regfile_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [IDX_W-1:0]  cmd_rs,
    input  logic [IDX_W-1:0]  cmd_rt,
    input  logic [IDX_W-1:0]  cmd_rd,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [IDX_W-1:0]  rf_read_reg1,
    output logic [IDX_W-1:0]  rf_read_reg2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic [IDX_W-1:0]  rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_reg_write,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err
);

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [IDX_W-1:0]    rd_q, rd_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    read_reg1_q, read_reg1_d;
    logic [IDX_W-1:0]    read_reg2_q, read_reg2_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic                rsp_err_q, rsp_err_d;
    logic                wr_en_q, wr_en_d;
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [DATA_W-1:0]   alu_result_s;
    logic                alu_err_s;

    rf_alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .imm    (imm_q),
        .result (alu_result_s),
        .err    (alu_err_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed READ->EXEC->WRITE->RESP walk after acceptance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Per-state next values of the command, operand, result and response registers.
    always_comb begin
        op_d        = op_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        read_reg1_d = read_reg1_q;
        read_reg2_d = read_reg2_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        err_d       = err_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    rd_d        = cmd_rd;
                    imm_d       = cmd_imm;
                    read_reg1_d = cmd_rs;
                    read_reg2_d = cmd_rt;
                end else begin
                    op_d = op_q;
                end
            end
            ST_READ: begin
                a_d = rf_read_data1;
                b_d = rf_read_data2;
            end
            ST_EXEC: begin
                result_d = alu_result_s;
                err_d    = alu_err_s;
            end
            ST_WRITE: begin
                rsp_data_d = result_q;
                rsp_zero_d = (result_q == {DATA_W{1'b0}});
                rsp_err_d  = err_q;
            end
            default: begin
                rsp_data_d = rsp_data_q;
            end
        endcase
        // Handshake flags follow the state being entered so they are registered.
        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // Command, operand, result and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q        <= 3'b000;
            rd_q        <= {IDX_W{1'b0}};
            imm_q       <= {DATA_W{1'b0}};
            read_reg1_q <= {IDX_W{1'b0}};
            read_reg2_q <= {IDX_W{1'b0}};
            a_q         <= {DATA_W{1'b0}};
            b_q         <= {DATA_W{1'b0}};
            result_q    <= {DATA_W{1'b0}};
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {DATA_W{1'b0}};
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            op_q        <= op_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            read_reg1_q <= read_reg1_d;
            read_reg2_q <= read_reg2_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Write-back next values: arm in WRITE, disarm in RESP, otherwise hold.
    always_comb begin
        wr_en_d   = wr_en_q;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        if (state_q == ST_WRITE) begin
            wr_en_d   = ~err_q;
            wr_idx_d  = rd_q;
            wr_data_d = result_q;
        end else if (state_q == ST_RESP) begin
            wr_en_d = 1'b0;
        end else begin
            wr_en_d = wr_en_q;
        end
    end

    // Falling-edge write stage so the file samples a settled request on the rising edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_idx_q  <= {IDX_W{1'b0}};
            wr_data_q <= {DATA_W{1'b0}};
        end else begin
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rf_read_reg1  = read_reg1_q;
    assign rf_read_reg2  = read_reg2_q;
    assign rf_write_reg  = wr_idx_q;
    assign rf_write_data = wr_data_q;
    assign rf_reg_write  = wr_en_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_zero      = rsp_zero_q;
    assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: a 4x32 register file stub,
// a transaction-level model checked every cycle, and directed scenarios
// with hand-computed literal expectations.
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_rs, cmd_rt, cmd_rd;
    logic [31:0] cmd_imm;
    logic [1:0]  rf_read_reg1, rf_read_reg2, rf_write_reg;
    logic [31:0] rf_read_data1, rf_read_data2, rf_write_data;
    logic        rf_reg_write;
    logic        rsp_valid, rsp_ready, rsp_zero, rsp_err;
    logic [31:0] rsp_data;

    int checks   = 0;
    int failures = 0;

    regfile_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_rs        (cmd_rs),
        .cmd_rt        (cmd_rt),
        .cmd_rd        (cmd_rd),
        .cmd_imm       (cmd_imm),
        .rf_read_reg1  (rf_read_reg1),
        .rf_read_reg2  (rf_read_reg2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_reg_write  (rf_reg_write),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_zero      (rsp_zero),
        .rsp_err       (rsp_err)
    );

    always #5 clk = ~clk;

    // Register file stub: combinational read, write on rising edge with RegWrite.
    logic [31:0] rf_mem [4] = '{default: 32'h0};
    assign rf_read_data1 = rf_mem[rf_read_reg1];
    assign rf_read_data2 = rf_mem[rf_read_reg2];
    always @(posedge clk) begin
        if (rf_reg_write) rf_mem[rf_write_reg] <= rf_write_data;
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, req);
        end
    endtask

    // Opcode semantics at the arithmetic level.
    function automatic void model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] imm, output logic [31:0] r, output logic legal);
        legal = 1'b1;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = imm;
            default: begin r = 32'h0; legal = 1'b0; end
        endcase
    endfunction

    // Transaction model: file contents, outstanding command and its age in cycles.
    logic [31:0] mrf [4] = '{default: 32'h0};
    bit          busy = 1'b0;
    int          age = 0;
    int          wr_cnt = 0;
    logic [1:0]  p_rs, p_rt, p_rd;
    logic [31:0] p_res;
    logic        p_legal;
    logic        m_acc, m_hs, m_wr;

    always begin
        @(posedge clk);
        m_acc = cmd_valid && cmd_ready;
        m_hs  = rsp_valid && rsp_ready;
        m_wr  = rf_reg_write;
        if (!reset) begin
            busy = 1'b0;
            age  = 0;
        end else if (busy) begin
            age = age + 1;
            if (m_wr) wr_cnt = wr_cnt + 1;
            if (age == 3 && p_legal) mrf[p_rd] = p_res;
            if (m_hs) begin
                chk32("writes_per_cmd", wr_cnt, p_legal ? 32'd1 : 32'd0);
                busy = 1'b0;
            end
        end else begin
            chk1("idle_reg_write", m_wr, 1'b0);
            if (m_acc) begin
                p_rs = cmd_rs;
                p_rt = cmd_rt;
                p_rd = cmd_rd;
                model_op(cmd_op, mrf[cmd_rs], mrf[cmd_rt], cmd_imm, p_res, p_legal);
                busy   = 1'b1;
                age    = 0;
                wr_cnt = 0;
            end
        end
        #1;
        if (reset) begin
            chk1("cmd_ready", cmd_ready, !busy);
            chk1("rsp_valid", rsp_valid, busy && age >= 3);
            chk1("rf_reg_write", rf_reg_write, busy && age == 3 && p_legal);
            if (busy && age == 0) begin
                chk32("rf_read_reg1", {30'd0, rf_read_reg1}, {30'd0, p_rs});
                chk32("rf_read_reg2", {30'd0, rf_read_reg2}, {30'd0, p_rt});
            end
            if (busy && age == 3 && p_legal) begin
                chk32("rf_write_reg", {30'd0, rf_write_reg}, {30'd0, p_rd});
                chk32("rf_write_data", rf_write_data, p_res);
            end
            if (busy && age >= 3) begin
                chk32("rsp_data", rsp_data, p_res);
                chk1("rsp_zero", rsp_zero, p_res == 32'h0);
                chk1("rsp_err", rsp_err, !p_legal);
            end
            if (!busy || age >= 3) begin
                for (int i = 0; i < 4; i++) chk32($sformatf("file_r%0d", i), rf_mem[i], mrf[i]);
            end
        end
    end

    logic [31:0] last_data;
    logic        last_zero, last_err;

    task automatic send_cmd(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rt,
                            input logic [1:0] rd, input logic [31:0] imm, output int waited);
        logic got;
        cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_imm = imm;
        cmd_valid = 1'b1;
        got = 1'b0;
        waited = 0;
        while (!got && waited < 20) begin
            @(posedge clk);
            got = cmd_ready;
            waited++;
        end
        #2;
        cmd_valid = 1'b0;
        chk1("accept_seen", got, 1'b1);
    endtask

    task automatic finish_rsp(input int hold);
        logic got;
        int   n;
        got = 1'b0;
        n = 0;
        while (!got && n < 20) begin
            @(posedge clk);
            #2;
            got = rsp_valid;
            n++;
        end
        chk1("rsp_seen", got, 1'b1);
        last_data = rsp_data;
        last_zero = rsp_zero;
        last_err  = rsp_err;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #2;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #2;
        rsp_ready = 1'b0;
    endtask

    task automatic run(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rt,
                       input logic [1:0] rd, input logic [31:0] imm, input int hold);
        int w;
        send_cmd(op, rs, rt, rd, imm, w);
        finish_rsp(hold);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = 3'd0; cmd_rs = 2'd0; cmd_rt = 2'd0; cmd_rd = 2'd0; cmd_imm = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_rf_reg_write", rf_reg_write, 1'b0);
        chk32("rst_rf_write_reg", {30'd0, rf_write_reg}, 32'd0);
        chk32("rst_rf_write_data", rf_write_data, 32'd0);
        chk32("rst_rf_read_regs", {28'd0, rf_read_reg1, rf_read_reg2}, 32'd0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk32("rst_rsp_data", rsp_data, 32'd0);
        chk1("rst_rsp_zero", rsp_zero, 1'b0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #2;

        // LDI r1
        run(3'b100, 2'd0, 2'd0, 2'd1, 32'hAFAFAFAF, 0);
        chk32("ldi_rsp_data", last_data, 32'hAFAFAFAF);
        chk1("ldi_rsp_zero", last_zero, 1'b0);
        chk32("ldi_file_r1", rf_mem[1], 32'hAFAFAFAF);

        // ADD wrap to zero
        run(3'b100, 2'd0, 2'd0, 2'd1, 32'hFFFFFFFF, 0);
        run(3'b100, 2'd0, 2'd0, 2'd2, 32'h00000001, 0);
        run(3'b000, 2'd1, 2'd2, 2'd3, 32'h0, 0);
        chk32("add_file_r3", rf_mem[3], 32'h0);
        chk1("add_rsp_zero", last_zero, 1'b1);

        // SUB with a second command (AND) waiting behind it
        send_cmd(3'b001, 2'd2, 2'd1, 2'd0, 32'h0, w);
        cmd_op = 3'b010; cmd_rs = 2'd1; cmd_rt = 2'd2; cmd_rd = 2'd3; cmd_imm = 32'h0;
        cmd_valid = 1'b1;
        finish_rsp(0);
        chk32("sub_rsp_data", last_data, 32'h00000002);
        chk32("sub_file_r0", rf_mem[0], 32'h00000002);
        send_cmd(3'b010, 2'd1, 2'd2, 2'd3, 32'h0, w);
        chk32("held_cmd_accept_edges", w, 32'd1);
        finish_rsp(0);
        chk32("and_rsp_data", last_data, 32'h00000001);

        // Illegal opcode leaves the destination alone
        run(3'b100, 2'd0, 2'd0, 2'd2, 32'h12345678, 0);
        run(3'b111, 2'd0, 2'd0, 2'd2, 32'hFFFF0000, 0);
        chk1("ill_rsp_err", last_err, 1'b1);
        chk32("ill_rsp_data", last_data, 32'h0);
        chk32("ill_file_r2", rf_mem[2], 32'h12345678);

        // Long response back-pressure
        run(3'b011, 2'd0, 2'd2, 2'd1, 32'h0, 10);
        chk32("or_rsp_data", last_data, 32'h1234567A);
        chk1("or_idle_after", cmd_ready, 1'b1);

        // Destination equal to both sources uses the old value
        run(3'b000, 2'd1, 2'd1, 2'd1, 32'h0, 0);
        chk32("self_add_file_r1", rf_mem[1], 32'h2468ACF4);

        // Reset in WRITE before the falling edge
        send_cmd(3'b100, 2'd0, 2'd0, 2'd3, 32'hDEADBEEF, w);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk1("abort1_reg_write", rf_reg_write, 1'b0);
        chk1("abort1_cmd_ready", cmd_ready, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk32("abort1_file_r3", rf_mem[3], 32'h00000001);
        chk1("abort1_idle", cmd_ready, 1'b1);

        // Reset in WRITE after the falling edge: the armed write drops at once
        send_cmd(3'b100, 2'd0, 2'd0, 2'd3, 32'h00000055, w);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk1("abort2_armed", rf_reg_write, 1'b1);
        reset = 1'b0;
        #1;
        chk1("abort2_async_drop", rf_reg_write, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk32("abort2_file_r3", rf_mem[3], 32'h00000001);

        // Operation after recovery
        run(3'b100, 2'd0, 2'd0, 2'd0, 32'h00000000, 0);
        chk1("ldi0_rsp_zero", last_zero, 1'b1);
        chk32("ldi0_file_r0", rf_mem[0], 32'h0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
